// File: rtl/reg_file.sv
// reg_file: RV32I integer register file with two combinational read ports, one write port and a debug dump stream
// Ports: clk, rst_n (async active-low); A1/A2 -> RD1/RD2 read ports; A3/WD3/WE3 write port (x0 always reads 0);
//        dump_start/dump_ready in, dump_valid/dump_addr/dump_data/dump_busy/dump_done out stream all registers.
// Option: define REGFILE_BYPASS_EN to forward WD3 to RD1/RD2/dump_data on an address match with the active write.
module reg_file #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4:0]      A1,
   input  logic [4:0]      A2,
   output logic [XLEN-1:0] RD1,
   output logic [XLEN-1:0] RD2,
   input  logic [4:0]      A3,
   input  logic [XLEN-1:0] WD3,
   input  logic            WE3,
   input  logic            dump_start,
   output logic            dump_valid,
   input  logic            dump_ready,
   output logic [4:0]      dump_addr,
   output logic [XLEN-1:0] dump_data,
   output logic            dump_busy,
   output logic            dump_done
);
   typedef enum logic {IDLE, RUN} state_t;
   logic [XLEN-1:0] regs [NREG];
   state_t          state, state_nxt;
   logic [4:0]      idx, idx_nxt;
   logic            done_q, done_nxt, last, fwd;
`ifdef REGFILE_BYPASS_EN
   assign fwd = WE3 && (A3 != '0);
`else
   assign fwd = 1'b0;
`endif
   assign RD1  = (A1 == '0) ? '0 : (fwd && A3 == A1) ? WD3 : regs[A1];
   assign RD2  = (A2 == '0) ? '0 : (fwd && A3 == A2) ? WD3 : regs[A2];
   assign last = idx == 5'(NREG - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      else if (WE3 && A3 != '0)
         regs[A3] <= WD3;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         done_q <= done_nxt;
      end
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      done_nxt  = 1'b0;
      if (state == IDLE) begin
         state_nxt = dump_start ? RUN : IDLE;
         idx_nxt   = '0;
      end else if (dump_ready) begin
         state_nxt = last ? IDLE : RUN;
         idx_nxt   = last ? '0 : idx + 5'd1;
         done_nxt  = last;
      end
   end
   always_comb begin
      dump_valid = state == RUN;
      dump_busy  = state == RUN;
      dump_addr  = idx;
      dump_data  = (idx == '0) ? '0 : (fwd && A3 == idx) ? WD3 : regs[idx];
      dump_done  = done_q;
   end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file with a scoreboard queue of expected dump beats
module tb_reg_file;
   logic        clk = 0, rst_n = 0;
   logic [4:0]  A1 = 0, A2 = 0, A3 = 0, dump_addr;
   logic [31:0] RD1, RD2, WD3 = 0, dump_data;
   logic        WE3 = 0, dump_start = 0, dump_ready = 0;
   logic        dump_valid, dump_busy, dump_done;
   int          errors = 0, checks = 0;
   logic [31:0] mdl [32];
   typedef struct packed {logic [4:0] a; logic [31:0] d;} beat_t;
   beat_t       q[$];
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   reg_file dut (
      .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
      .A3(A3), .WD3(WD3), .WE3(WE3), .dump_start(dump_start), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
      .dump_busy(dump_busy), .dump_done(dump_done)
   );

   always #5 clk = ~clk;

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      A3 = a; WD3 = d; WE3 = 1;
      @(negedge clk);
      WE3 = 0;
      if (a != 0) mdl[a] = d;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 32; i++) mdl[i] = 0;
      rst_n = 0; A1 = 5; A2 = 31;
      #1;
      checks++; if (RD1 !== 0) begin errors++; $display("FAIL reset_rd1: got %h expected 0", RD1); end
      checks++; if (RD2 !== 0) begin errors++; $display("FAIL reset_rd2: got %h expected 0", RD2); end
      checks++; if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got v/b/d=%b expected 000", {dump_valid, dump_busy, dump_done}); end
      checks++; if (dump_addr !== 0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", dump_addr); end
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_write_read;
      wr(7, 32'hDEADBEEF);
      A1 = 7; #1;
      checks++; if (RD1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd1: got %h expected deadbeef", RD1); end
      wr(0, 32'h1234);
      A1 = 0; A2 = 0; #1;
      checks++; if (RD2 !== 0) begin errors++; $display("FAIL x0_rd2: got %h expected 0", RD2); end
      checks++; if (RD1 !== 0) begin errors++; $display("FAIL x0_rd1: got %h expected 0", RD1); end
   endtask

   task automatic test_same_cycle;
      logic [31:0] exp;
      @(negedge clk);
      A3 = 9; WD3 = 32'hA5A5A5A5; WE3 = 1; A1 = 9; A2 = 7;
      #1;
      exp = BYP ? 32'hA5A5A5A5 : mdl[9];
      checks++; if (RD1 !== exp) begin errors++; $display("FAIL same_cycle_rd1: got %h expected %h", RD1, exp); end
      checks++; if (RD2 !== mdl[7]) begin errors++; $display("FAIL same_cycle_rd2: got %h expected %h", RD2, mdl[7]); end
      @(negedge clk);
      WE3 = 0; mdl[9] = 32'hA5A5A5A5;
      #1;
      checks++; if (RD1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL after_write_rd1: got %h expected a5a5a5a5", RD1); end
   endtask

   task automatic test_dump_full;
      beat_t got, exp;
      for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h11);
      q.delete();
      for (int i = 0; i < 32; i++) q.push_back({5'(i), (i == 0) ? 32'h0 : mdl[i]});
      @(negedge clk);
      dump_ready = 1; dump_start = 1;
      #1;
      checks++; if (dump_valid !== 0) begin errors++; $display("FAIL full_latency: got valid=%b expected 0", dump_valid); end
      @(negedge clk);
      dump_start = 0;
      for (int c = 0; c < 32; c++) begin
         #1;
         checks++; if (dump_valid !== 1 || dump_busy !== 1 || dump_done !== 0) begin errors++; $display("FAIL full_ctl beat %0d: got v/b/d=%b expected 110", c, {dump_valid, dump_busy, dump_done}); end
         got = {dump_addr, dump_data};
         exp = q.pop_front();
         checks++; if (got !== exp) begin errors++; $display("FAIL full_beat: got addr=%0d data=%h expected addr=%0d data=%h", got.a, got.d, exp.a, exp.d); end
         if (c == 31) dump_start = 1;
         @(negedge clk);
      end
      dump_start = 0;
      #1;
      checks++; if ({dump_done, dump_valid, dump_busy} !== 3'b100) begin errors++; $display("FAIL full_done: got d/v/b=%b expected 100", {dump_done, dump_valid, dump_busy}); end
      @(negedge clk); #1;
      checks++; if ({dump_done, dump_valid, dump_busy} !== 3'b000) begin errors++; $display("FAIL full_after: got d/v/b=%b expected 000", {dump_done, dump_valid, dump_busy}); end
      checks++; if (q.size() !== 0) begin errors++; $display("FAIL full_queue: got %0d left expected 0", q.size()); end
   endtask

   task automatic test_dump_backpressure;
      beat_t got, exp, prev;
      logic [31:0] d;
      int beats = 0, cyc = 0;
      bit hold = 0;
      q.delete();
      for (int i = 0; i < 32; i++) begin
         d = (i == 0) ? 32'h0 : mdl[i];
         if (i == 25) d = 32'h25252525;
         if (i == 12 && BYP) d = 32'h12121212;
         q.push_back({5'(i), d});
      end
      @(negedge clk);
      dump_ready = 0; dump_start = 1;
      @(negedge clk);
      dump_start = 0;
      while (beats < 32 && cyc < 200) begin
         dump_ready = (cyc % 3 == 0);
         dump_start = (cyc == 20);
         if (dump_ready && beats == 3) begin A3 = 25; WD3 = 32'h25252525; WE3 = 1; end
         if (dump_ready && beats == 12) begin A3 = 12; WD3 = 32'h12121212; WE3 = 1; end
         #1;
         got = {dump_addr, dump_data};
         if (hold) begin
            checks++; if (got !== prev) begin errors++; $display("FAIL bp_hold: got addr=%0d data=%h expected addr=%0d data=%h", got.a, got.d, prev.a, prev.d); end
         end
         checks++; if (dump_valid !== 1) begin errors++; $display("FAIL bp_valid cycle %0d: got %b expected 1", cyc, dump_valid); end
         if (dump_ready) begin
            exp = q.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL bp_beat: got addr=%0d data=%h expected addr=%0d data=%h", got.a, got.d, exp.a, exp.d); end
            beats++; hold = 0;
         end else begin
            prev = got; hold = 1;
         end
         @(negedge clk);
         WE3 = 0; dump_start = 0; cyc++;
      end
      mdl[25] = 32'h25252525; mdl[12] = 32'h12121212;
      checks++; if (beats !== 32) begin errors++; $display("FAIL bp_timeout: got %0d beats expected 32", beats); end
      #1;
      checks++; if (dump_done !== 1) begin errors++; $display("FAIL bp_done: got %b expected 1", dump_done); end
      @(negedge clk); #1;
      checks++; if ({dump_done, dump_valid} !== 2'b00) begin errors++; $display("FAIL bp_after: got d/v=%b expected 00", {dump_done, dump_valid}); end
      A1 = 12; A2 = 25; #1;
      checks++; if ({RD1, RD2} !== {mdl[12], mdl[25]}) begin errors++; $display("FAIL bp_regs: got %h %h expected %h %h", RD1, RD2, mdl[12], mdl[25]); end
   endtask

   task automatic test_dump_reset;
      beat_t got, exp;
      q.delete();
      for (int i = 0; i < 32; i++) q.push_back({5'(i), (i == 0) ? 32'h0 : mdl[i]});
      @(negedge clk);
      dump_ready = 1; dump_start = 1;
      @(negedge clk);
      dump_start = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         got = {dump_addr, dump_data};
         exp = q.pop_front();
         checks++; if (got !== exp) begin errors++; $display("FAIL rst_beat: got addr=%0d data=%h expected addr=%0d data=%h", got.a, got.d, exp.a, exp.d); end
         @(negedge clk);
      end
      #1;
      checks++; if (dump_addr !== 10 || dump_valid !== 1) begin errors++; $display("FAIL rst_pre: got addr=%0d valid=%b expected 10 1", dump_addr, dump_valid); end
      rst_n = 0;
      #1;
      checks++; if ({dump_valid, dump_busy, dump_done} !== 3'b000 || dump_addr !== 0) begin errors++; $display("FAIL rst_abort: got v/b/d=%b addr=%0d expected 000 0", {dump_valid, dump_busy, dump_done}, dump_addr); end
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 32; i++) mdl[i] = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         checks++; if ({dump_valid, dump_done} !== 2'b00) begin errors++; $display("FAIL rst_nodone: got v/d=%b expected 00", {dump_valid, dump_done}); end
      end
      for (int a = 0; a < 32; a++) begin
         A1 = 5'(a); A2 = 5'(31 - a); #1;
         checks++; if (RD1 !== 0 || RD2 !== 0) begin errors++; $display("FAIL rst_regs x%0d: got %h %h expected 0 0", a, RD1, RD2); end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_read();
      test_same_cycle();
      test_dump_full();
      test_dump_backpressure();
      test_dump_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
